// File: rtl/gate_truth_checker.sv
// Gate truth-table checker: sweeps the four input vectors of a two-input gate
// under test, samples its output after a settle delay and accumulates
// mismatches against a latched expected truth table.
module gate_truth_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int REPEAT        = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [3:0]       truth_table,
   output logic             gate_a,
   output logic             gate_b,
   input  logic             gate_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [3:0]       fail_mask,
   output logic [CNT_W-1:0] fail_count
);

   localparam int SETW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int SWPW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam logic [SETW-1:0]  SETTLE_LAST = SETW'(SETTLE_CYCLES - 1);
   localparam logic [SWPW-1:0]  SWEEP_LAST  = SWPW'(REPEAT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       table_q, table_d;
   logic [1:0]       idx_q, idx_d;
   logic [SWPW-1:0]  sweep_q, sweep_d;
   logic [SETW-1:0]  settleCnt_q, settleCnt_d;
   logic             gateA_q, gateA_d;
   logic             gateB_q, gateB_d;
   logic [3:0]       failMask_q, failMask_d;
   logic [CNT_W-1:0] failCount_q, failCount_d;

   logic             startOk;
   logic             sampleMiss;
   logic             launch;
   logic             toIdle;

   // A start that coincides with abort is dropped; abort always wins.
   assign startOk    = start && !abort;
   assign sampleMiss = (gate_out != table_q[idx_q]);

   // Next-state logic: sequencing through vectors, sweeps and result capture.
   always_comb begin
      state_d     = state_q;
      table_d     = table_q;
      idx_d       = idx_q;
      sweep_d     = sweep_q;
      settleCnt_d = settleCnt_q;
      gateA_d     = gateA_q;
      gateB_d     = gateB_q;
      failMask_d  = failMask_q;
      failCount_d = failCount_q;
      launch      = 1'b0;
      toIdle      = 1'b0;

      case (state_q)
         IDLE: begin
            if (startOk) begin
               launch = 1'b1;
            end
         end
         SETTLE: begin
            if (abort) begin
               toIdle = 1'b1;
            end else if (settleCnt_q == SETTLE_LAST) begin
               settleCnt_d = '0;
               state_d     = SAMPLE;
            end else begin
               settleCnt_d = settleCnt_q + SETW'(1);
            end
         end
         SAMPLE: begin
            if (abort) begin
               toIdle = 1'b1;
            end else begin
               if (sampleMiss) begin
                  failMask_d[idx_q] = 1'b1;
                  if (failCount_q != CNT_MAX) begin
                     failCount_d = failCount_q + CNT_W'(1);
                  end
               end
               settleCnt_d = '0;
               if (idx_q != 2'd3) begin
                  idx_d              = idx_q + 2'd1;
                  {gateA_d, gateB_d} = idx_q + 2'd1;
                  state_d            = SETTLE;
               end else if (sweep_q != SWEEP_LAST) begin
                  sweep_d            = sweep_q + SWPW'(1);
                  idx_d              = 2'd0;
                  {gateA_d, gateB_d} = 2'b00;
                  state_d            = SETTLE;
               end else begin
                  idx_d              = 2'd0;
                  sweep_d            = '0;
                  {gateA_d, gateB_d} = 2'b00;
                  state_d            = DONE;
               end
            end
         end
         DONE: begin
            if (abort) begin
               toIdle = 1'b1;
            end else if (startOk) begin
               launch = 1'b1;
            end
         end
         default: begin
            toIdle = 1'b1;
         end
      endcase

      if (toIdle) begin
         state_d            = IDLE;
         idx_d              = 2'd0;
         sweep_d            = '0;
         settleCnt_d        = '0;
         {gateA_d, gateB_d} = 2'b00;
      end else if (launch) begin
         state_d            = SETTLE;
         table_d            = truth_table;
         idx_d              = 2'd0;
         sweep_d            = '0;
         settleCnt_d        = '0;
         {gateA_d, gateB_d} = 2'b00;
         failMask_d         = 4'b0000;
         failCount_d        = '0;
      end
   end

   // State and datapath registers, cleared asynchronously by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         table_q     <= 4'b0000;
         idx_q       <= 2'd0;
         sweep_q     <= '0;
         settleCnt_q <= '0;
         gateA_q     <= 1'b0;
         gateB_q     <= 1'b0;
         failMask_q  <= 4'b0000;
         failCount_q <= '0;
      end else begin
         state_q     <= state_d;
         table_q     <= table_d;
         idx_q       <= idx_d;
         sweep_q     <= sweep_d;
         settleCnt_q <= settleCnt_d;
         gateA_q     <= gateA_d;
         gateB_q     <= gateB_d;
         failMask_q  <= failMask_d;
         failCount_q <= failCount_d;
      end
   end

   assign gate_a     = gateA_q;
   assign gate_b     = gateB_q;
   assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
   assign done       = (state_q == DONE);
   assign pass       = done && (failCount_q == '0);
   assign fail_mask  = failMask_q;
   assign fail_count = failCount_q;

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
Stimulus/response end of the two-input gate interface. It drives operands a/b into a combinational 2-input gate under test (OR, AND, XOR, ...). It sweeps all four input vectors, samples the gate output after a settle delay, and compares each sample against a 4-bit expected truth table. Pass/fail results are accumulated for bring-up and self-test of the gate library.

Parameters:
SETTLE_CYCLES, 2, cycles operands are held before the output is sampled (legal range >=1)
REPEAT, 1, number of full 4-vector sweeps per run (legal range >=1)
CNT_W, 8, width of the mismatch counter

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; honoured only in IDLE or DONE
abort  input  1  synchronous abort; returns to IDLE from any non-IDLE state
truth_table  input  4  expected output; bit i = expected out for vector i, where a=i[1] and b=i[0]; latched on start
gate_a  output  1  registered operand a to the gate under test
gate_b  output  1  registered operand b to the gate under test
gate_out  input  1  output of the gate under test
busy  output  1  high in SETTLE and SAMPLE
done  output  1  high in DONE; stays high until the next start or abort
pass  output  1  done && (fail_count == 0)
fail_mask  output  4  bit i set if vector i mismatched in any sweep
fail_count  output  CNT_W  total mismatching samples, saturating at all-ones

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE. gate_a, gate_b, busy, done, pass, fail_mask, fail_count, the vector index and the counters are all 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- Start: at edge k with start=1 in IDLE or DONE:
  - latch truth_table; clear fail_mask, fail_count and done;
  - idx=0, sweep=0; gate_a/gate_b := vector 0; state := SETTLE; settle counter := 0.
- SETTLE: operands held. The state lasts exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE: lasts 1 cycle. gate_out is captured at the edge ending SAMPLE and compared with the latched truth_table[idx]. On mismatch:
  - set fail_mask[idx];
  - fail_count := fail_count+1, held if already all-ones.
- After SAMPLE:
  - if idx<3: idx+1, drive the new vector, go to SETTLE;
  - else if sweep<REPEAT-1: sweep+1, idx=0, drive vector 0, go to SETTLE;
  - else go to DONE.
- Operands change only on the edge that enters SETTLE, so each vector is held for SETTLE_CYCLES+1 cycles.
- Latency: done rises at edge k + REPEAT*4*(SETTLE_CYCLES+1). Defaults give k+12.
- DONE: gate_a/gate_b return to 0. done=1. Results are stable until the next start.
- start while busy: ignored.
- start and abort asserted in the same cycle: abort wins.
- abort in SETTLE/SAMPLE/DONE: next state IDLE, gate_a/gate_b/done=0. fail_mask and fail_count retain their partial values until the next start. pass=0.
- abort in IDLE: no effect.
- rst_n deassertion mid-run: the FSM stays in IDLE; no run resumes.
- truth_table changes while busy: no effect, because the value latched at start is used.
- pass is combinational from done and fail_count; it is never high outside DONE.

Test Plan:
1. Defaults, truth_table=4'b1110, ideal OR gate connected, start pulse at edge k -> gate_a/gate_b step 00,01,10,11 every 3 cycles; done=1 at k+12; pass=1, fail_mask=0000, fail_count=0.
2. Same table, gate_out tied to 0 -> done at k+12; pass=0, fail_mask=4'b1110, fail_count=3.
3. REPEAT=3, ideal OR gate, but gate_out forced low only during the second sweep's vector 2 -> done at k+36; fail_mask=4'b0100, fail_count=1.
4. CNT_W=2, REPEAT=2, gate_out tied to 0, table 4'b1110 -> 6 mismatches saturate the counter; fail_count=2'b11, fail_mask=4'b1110.
5. Run started, abort asserted in the SETTLE of vector 2 -> IDLE next cycle; busy=0, done=0, gate_a/gate_b=0; fail_mask/fail_count retained. start pulsed during busy in a separate run -> ignored; done timing unchanged.
6. rst_n pulled low during SAMPLE of vector 1 -> all outputs 0 immediately (asynchronous). After release the block stays IDLE. A new start then produces a clean run per scenario 1.
